data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Word-organised data memory with byte/half/word write lanes, a
// latency-programmable read FSM and one-cycle error/valid pulses.
module data_mem_responder #(
  parameter int unsigned DEPTH        = 16384,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_read,
  input  logic [3:0]  data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        busy,
  output logic        addr_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 2;
  localparam logic [CW-1:0] LAT_LOAD = CW'(READ_LATENCY - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  logic [31:0]   mem_q [DEPTH];

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          busy_q, busy_d;
  logic          addr_err_q, addr_err_d;

  logic [1:0]    wr_off;
  logic          wr_illegal;
  logic          wr_oor;
  logic          wr_en;
  logic          wr_err;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  logic [31:0]   rd_addr;
  logic          rd_oor;
  logic [31:0]   rd_word;
  logic [31:0]   rd_data;
  logic          rd_done;

  // Strobe decode: lane offset comes from the strobe pattern itself
  always_comb begin
    wr_off     = 2'd0;
    wr_illegal = 1'b0;
    case (data_write)
      4'b0000:                   wr_off = 2'd0;
      4'b1111, 4'b1100, 4'b1000: wr_off = 2'd0;
      4'b0110, 4'b0100:          wr_off = 2'd1;
      4'b0011, 4'b0010:          wr_off = 2'd2;
      4'b0001:                   wr_off = 2'd3;
      default:                   wr_illegal = 1'b1;
    endcase
  end

  // Write qualification; byte enable k maps to strobe bit 3-k
  always_comb begin
    wr_oor  = ({2'b00, data_addr[31:2]} >= 32'(DEPTH));
    wr_en   = (|data_write) && !wr_illegal && !wr_oor;
    wr_err  = (|data_write) && (wr_illegal || wr_oor);
    wr_be   = {data_write[0], data_write[1], data_write[2], data_write[3]};
    wr_data = data_in << {wr_off, 3'b000};
  end

  // Read path sees pre-write contents on a shared edge
  always_comb begin
    rd_addr = (state_q == IDLE) ? data_addr : addr_q;
    rd_oor  = ({2'b00, rd_addr[31:2]} >= 32'(DEPTH));
    rd_word = rd_oor ? 32'h0 : mem_q[rd_addr[AW+1:2]];
    rd_data = rd_word >> {rd_addr[1:0], 3'b000};
  end

  // Read FSM next-state and registered output values
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    addr_err_d   = wr_err;
    rd_done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_read) begin
          addr_d = data_addr;
          if (READ_LATENCY <= 1) begin
            rd_done = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          rd_done = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (rd_done) begin
      data_out_d   = rd_data;
      data_valid_d = 1'b1;
      addr_err_d   = wr_err | rd_oor;
    end
    busy_d = (state_d == WAIT);
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Storage array; untouched by reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) begin
          mem_q[data_addr[AW+1:2]][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign addr_err   = addr_err_q;

endmodule
